// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: default ICCM geometry, reset PC and fetch FSM states.
package riscv_pkg;
   localparam int ADDR_WIDTH = 11;
   localparam int DATA_WIDTH = 32;
   localparam int RESET_PC   = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/ifu_fifo.sv
// First-word-fall-through prefetch buffer with push, pop, flush and occupancy count.
module ifu_fifo #(
   parameter int WIDTH = 43,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      // a push into a full buffer is only accepted when a pop frees the slot
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: credit-limited ICCM read issue feeding an FWFT prefetch buffer.
module ifu_fetch #(
   parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(riscv_pkg::RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_en,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   input  logic                  wr_busy,
   output logic                  cntlr_rd,
   output logic [ADDR_WIDTH-1:0] cntlr_raddr,
   input  logic [DATA_WIDTH-1:0] cntlr_rd_data,
   input  logic                  cntlr_rd_valid,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [ADDR_WIDTH-1:0] if_pc,
   input  logic                  id_ready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = ADDR_WIDTH + DATA_WIDTH;

   riscv_pkg::fetch_state_e state_q, state_d;
   logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0]   tag_q, tag_d;
   logic                    inflight_q, inflight_d;

   logic [FW-1:0] head;
   logic [CW-1:0] fifo_count;
   logic          fifo_valid, credit_ok, rd_issue, push, pop;

   always_comb begin
      fifo_valid = (fifo_count != '0);
      credit_ok  = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
      rd_issue   = (state_q == riscv_pkg::ST_FETCH) && credit_ok && !wr_busy && !redirect_valid;
      // responses with no matching issue, or landing in a redirect cycle, are dropped
      push       = cntlr_rd_valid && inflight_q && !redirect_valid;
      pop        = fifo_valid && id_ready && !redirect_valid;

      fetch_pc_d = fetch_pc_q;
      if (redirect_valid)  fetch_pc_d = redirect_addr;
      else if (rd_issue)   fetch_pc_d = fetch_pc_q + 1'b1;

      tag_d      = rd_issue ? fetch_pc_q : tag_q;
      inflight_d = rd_issue;

      state_d = state_q;
      if (!fetch_en) begin
         state_d = riscv_pkg::ST_IDLE;
      end else begin
         case (state_q)
            riscv_pkg::ST_IDLE:  state_d = riscv_pkg::ST_FETCH;
            riscv_pkg::ST_FETCH: state_d = credit_ok ? riscv_pkg::ST_FETCH : riscv_pkg::ST_HOLD;
            riscv_pkg::ST_HOLD:  state_d = credit_ok ? riscv_pkg::ST_FETCH : riscv_pkg::ST_HOLD;
            default:             state_d = riscv_pkg::ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= riscv_pkg::ST_IDLE;
         fetch_pc_q <= RESET_PC;
         tag_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
      end
   end

   ifu_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .wr_data ({tag_q, cntlr_rd_data}),
      .head    (head),
      .count   (fifo_count)
   );

   assign cntlr_rd    = rd_issue;
   assign cntlr_raddr = rd_issue ? fetch_pc_q : '0;
   assign if_valid    = fifo_valid;
   assign if_pc       = fifo_valid ? head[FW-1:DATA_WIDTH] : '0;
   assign if_instr    = fifo_valid ? head[DATA_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed and randomized bench for ifu_fetch against a queue-based reference model.
`timescale 1ns/1ps
module tb_ifu_fetch;
   localparam int AW    = 11;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam logic [AW-1:0] RPC = '0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fetch_en = 1'b0, redirect_valid = 1'b0, wr_busy = 1'b0, id_ready = 1'b0, spur = 1'b0;
   logic [AW-1:0] redirect_addr = '0;
   logic          cntlr_rd;
   logic [AW-1:0] cntlr_raddr;
   logic [DW-1:0] cntlr_rd_data = '0;
   logic          cntlr_rd_valid = 1'b0;
   logic          if_valid;
   logic [DW-1:0] if_instr;
   logic [AW-1:0] if_pc;
   logic [DW-1:0] scramble = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   ifu_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr), .wr_busy(wr_busy), .cntlr_rd(cntlr_rd),
      .cntlr_raddr(cntlr_raddr), .cntlr_rd_data(cntlr_rd_data), .cntlr_rd_valid(cntlr_rd_valid),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
   );

   // ICCM: one-cycle read latency, data derived from the address; spur injects unsolicited responses
   always @(posedge clk) begin
      cntlr_rd_valid <= cntlr_rd | spur;
      cntlr_rd_data  <= DW'(cntlr_raddr) ^ scramble;
   end

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   int            mst;
   logic [AW-1:0] mpc;
   logic          minfl;
   ent_t          mtag;
   logic [AW-1:0] strobe_log[$];
   logic [AW-1:0] pop_log[$];
   int            first_strobe, first_valid;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] at(input logic [AW-1:0] q[$], input int i);
      return (q.size() > i) ? q[i] : '1;
   endfunction

   function automatic logic exp_rd();
      return (mst == 1) && ((mq.size() + int'(minfl)) < DEPTH) && !wr_busy && !redirect_valid;
   endfunction

   task automatic model_reset();
      mq.delete();
      mst   = 0;
      mpc   = RPC;
      minfl = 1'b0;
   endtask

   task automatic clear_logs();
      strobe_log.delete();
      pop_log.delete();
      first_strobe = -1;
      first_valid  = -1;
   endtask

   task automatic cycle();
      logic erd, ev, credit;
      ent_t hd;
      @(negedge clk);
      erd = exp_rd();
      ev  = (mq.size() != 0);
      hd  = ev ? mq[0] : '0;
      chk("cntlr_rd",    64'(cntlr_rd),    64'(erd));
      chk("cntlr_raddr", 64'(cntlr_raddr), erd ? 64'(mpc) : 64'd0);
      chk("if_valid",    64'(if_valid),    64'(ev));
      chk("if_pc",       64'(if_pc),       64'(hd.pc));
      chk("if_instr",    64'(if_instr),    64'(hd.d));
      chk("fifo_count",  64'(dut.u_fifo.count_q), 64'(mq.size()));
      if (cntlr_rd) begin
         strobe_log.push_back(cntlr_raddr);
         if (first_strobe < 0) first_strobe = cyc;
      end
      if (if_valid && id_ready && !redirect_valid) pop_log.push_back(if_pc);
      if (if_valid && first_valid < 0) first_valid = cyc;
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         credit = (mq.size() + int'(minfl)) < DEPTH;
         if (redirect_valid) begin
            mq.delete();
            mpc = redirect_addr;
         end else begin
            if (ev && id_ready) void'(mq.pop_front());
            if (minfl) mq.push_back(mtag);
            if (erd) begin
               mtag = '{pc: mpc, d: DW'(mpc) ^ scramble};
               mpc  = mpc + 1'b1;
            end
         end
         minfl = erd;
         if (!fetch_en)     mst = 0;
         else if (mst == 0) mst = 1;
         else               mst = credit ? 1 : 2;
      end
      #1;
   endtask

   task automatic reset_now(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_if_valid"},    64'(if_valid),    64'd0);
      chk({tag, "_cntlr_rd"},    64'(cntlr_rd),    64'd0);
      chk({tag, "_cntlr_raddr"}, 64'(cntlr_raddr), 64'd0);
      chk({tag, "_if_pc"},       64'(if_pc),       64'd0);
      chk({tag, "_if_instr"},    64'(if_instr),    64'd0);
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] base;
      mtag = '0;
      clear_logs();
      reset_now("rst0");
      repeat (2) cycle();

      // Stream from reset with data == address
      rst_n = 1'b1; fetch_en = 1'b1; id_ready = 1'b1;
      clear_logs();
      repeat (12) cycle();
      for (int i = 0; i < 8; i++) chk("a_raddr_seq", 64'(at(strobe_log, i)), 64'(i));
      for (int i = 0; i < 6; i++) chk("a_pop_seq",   64'(at(pop_log, i)),    64'(i));
      chk("a_first_valid_lat", 64'(first_valid - first_strobe), 64'd2);

      // Back-pressure fills the buffer, then drains in order
      scramble = 32'hA5C3_0000;
      id_ready = 1'b0;
      clear_logs();
      repeat (10) cycle();
      chk("b_rd_stopped", 64'(cntlr_rd), 64'd0);
      chk("b_state_hold", 64'(dut.state_q), 64'(riscv_pkg::ST_HOLD));
      chk("b_count_full", 64'(dut.u_fifo.count_q), 64'(DEPTH));
      base = mq[0].pc;
      id_ready = 1'b1;
      clear_logs();
      repeat (12) cycle();
      for (int i = 0; i < 10; i++) chk("b_pop_order", 64'(at(pop_log, i)), 64'(AW'(base + AW'(i))));

      // Redirect with 3 buffered entries and one read in flight
      id_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mq.size() == 3 && minfl) break;
         cycle();
      end
      chk("c_setup_count", 64'(dut.u_fifo.count_q), 64'd3);
      redirect_valid = 1'b1; redirect_addr = 11'h100;
      cycle();
      redirect_valid = 1'b0; id_ready = 1'b1;
      chk("c_flushed_valid", 64'(if_valid), 64'd0);
      chk("c_flushed_count", 64'(dut.u_fifo.count_q), 64'd0);
      clear_logs();
      repeat (8) cycle();
      chk("c_first_raddr", 64'(at(strobe_log, 0)), 64'h100);
      chk("c_first_pc",    64'(at(pop_log, 0)),    64'h100);

      // Write-port contention at fetch_pc 0x20
      redirect_valid = 1'b1; redirect_addr = 11'h01C;
      cycle();
      redirect_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mpc == 11'h020 && mst == 1) break;
         cycle();
      end
      wr_busy = 1'b1;
      #1 chk("d_busy1_rd", 64'(cntlr_rd), 64'd0);
      cycle();
      #1 chk("d_busy2_rd", 64'(cntlr_rd), 64'd0);
      cycle();
      wr_busy = 1'b0;
      #1 chk("d_resume_rd",   64'(cntlr_rd),    64'd1);
      chk("d_resume_addr", 64'(cntlr_raddr), 64'h020);
      cycle();

      // Address wrap at the top of the ICCM
      redirect_valid = 1'b1; redirect_addr = 11'h7FE;
      cycle();
      redirect_valid = 1'b0;
      clear_logs();
      repeat (10) cycle();
      chk("e_wrap0", 64'(at(pop_log, 0)), 64'h7FE);
      chk("e_wrap1", 64'(at(pop_log, 1)), 64'h7FF);
      chk("e_wrap2", 64'(at(pop_log, 2)), 64'h000);

      // Randomized traffic
      scramble = $urandom;
      for (int i = 0; i < 400; i++) begin
         fetch_en       = ($urandom_range(0, 9) != 0);
         id_ready       = ($urandom_range(0, 3) != 0);
         wr_busy        = ($urandom_range(0, 4) == 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_addr  = AW'($urandom);
         spur           = ($urandom_range(0, 7) == 0);
         cycle();
      end
      fetch_en = 1'b1; id_ready = 1'b0; wr_busy = 1'b0; redirect_valid = 1'b0; spur = 1'b0;

      // Reset with a full buffer
      for (int i = 0; i < 20; i++) begin
         if (mq.size() == DEPTH) break;
         cycle();
      end
      chk("g_full_count", 64'(dut.u_fifo.count_q), 64'(DEPTH));
      reset_now("g_rst");
      repeat (2) cycle();
      rst_n = 1'b1; id_ready = 1'b1;
      clear_logs();
      repeat (6) cycle();
      chk("g_first_issue", 64'(at(strobe_log, 0)), 64'(RPC));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
